// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
// Holds the default word length, the FSM state encoding and the counter width helper.
package piso_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Modulo-WIDTH bit counter for the transmitter: clear, enable, and a
// terminal-count flag raised while the counter sits on WIDTH-1.
module piso_bitcnt
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CNT_LAST);

    // Clear wins over enable so a reload on the final bit restarts at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter, MSB first, with valid/ready load
// handshake, line-rate stall, one-shot or rotate mode, and back-to-back words.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no word in flight; Sout = 0, load_ready = 1
//   SHIFT | sreg[WIDTH-1] on Sout; advances one bit per shift_en cycle
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] Pin,
    input  logic             SW,
    input  logic             shift_en,
    output logic             Sout,
    output logic             sout_valid,
    output logic             sout_last
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic             tc;
    logic             cnt_clr;
    logic             cnt_en;
    logic             hs;
    logic             fill;

    piso_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    // In rotate mode the final bit never frees the slot, so load_valid is ignored.
    assign load_ready = (state == IDLE) || ((state == SHIFT) && tc && shift_en && !SW);
    assign hs         = load_valid && load_ready;
    assign fill       = SW ? sreg[WIDTH-1] : 1'b0;

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = Pin;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (hs) begin
                        sreg_nxt = Pin;
                        cnt_clr  = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (tc && !SW) begin
                            state_nxt = IDLE;
                            sreg_nxt  = '0;
                        end else begin
                            sreg_nxt = {sreg[WIDTH-2:0], fill};
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sreg_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
        end
    end

    assign sout_valid = (state == SHIFT);
    assign Sout       = (state == SHIFT) && sreg[WIDTH-1];
    assign sout_last  = (state == SHIFT) && tc;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: expected serial bits are queued per word
// and popped as the transmitter consumes them; a SIPO model checks loopback.
module tb_piso_tx;

    localparam int W = 8;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         load_valid = 1'b0;
    logic         SW         = 1'b0;
    logic         shift_en   = 1'b0;
    logic [W-1:0] Pin        = '0;
    logic         load_ready;
    logic         Sout;
    logic         sout_valid;
    logic         sout_last;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] rx;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .Pin        (Pin),
        .SW         (SW),
        .shift_en   (shift_en),
        .Sout       (Sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    always #5 clk = ~clk;

    // Team SIPO receiver model: enable tied to sout_valid, shifts into the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx <= '0;
        else if (sout_valid) rx <= {rx[W-2:0], Sout};
    end

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            exp_t t;
            t.b    = w[i];
            t.last = (i == 0);
            exp_q.push_back(t);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (Sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got Sout=%b valid=%b last=%b ready=%b exp 0 0 0 1",
                     Sout, sout_valid, sout_last, load_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        rst = 1'b1; Pin = 8'hA5; load_valid = 1'b1; SW = 1'b0; shift_en = 1'b1;
        push_word(8'hA5);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                e = exp_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last) begin
                    errors++;
                    $display("FAIL single_bit k=%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             k, sout_valid, Sout, sout_last, e.b, e.last);
                end
            end else begin
                checks++;
                if (sout_valid !== 1'b0 || Sout !== 1'b0 || load_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_idle got v=%b s=%b r=%b exp 0 0 1", sout_valid, Sout, load_ready);
                end
            end
            if (k == 8) begin
                checks++;
                if (load_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_ready_last got %b exp 1", load_ready);
                end
            end
            if (k == 1) load_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        Pin = 8'h81; load_valid = 1'b1; SW = 1'b0; shift_en = 1'b1;
        push_word(8'h81);
        push_word(8'h7E);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k <= 16) begin
                e = exp_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last) begin
                    errors++;
                    $display("FAIL b2b_bit k=%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             k, sout_valid, Sout, sout_last, e.b, e.last);
                end
                checks++;
                if (load_ready !== (k == 8 || k == 16)) begin
                    errors++;
                    $display("FAIL b2b_ready k=%0d got %b exp %b", k, load_ready, (k == 8 || k == 16));
                end
            end else begin
                checks++;
                if (sout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle got v=%b exp 0", sout_valid);
                end
            end
            if (k == 1) Pin = 8'h7E;
            if (k == 9) load_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        Pin = 8'hC3; load_valid = 1'b1; SW = 1'b0; shift_en = 1'b1;
        push_word(8'hC3);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (k <= 11) begin
                e = exp_q[0];
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last) begin
                    errors++;
                    $display("FAIL stall_bit k=%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             k, sout_valid, Sout, sout_last, e.b, e.last);
                end
                shift_en = !(k >= 2 && k <= 4);
                if (shift_en) void'(exp_q.pop_front());
            end else begin
                checks++;
                if (sout_valid !== 1'b0 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL stall_done got v=%b left=%0d exp v=0 left=0", sout_valid, exp_q.size());
                end
            end
        end
        shift_en = 1'b1;
    endtask

    task automatic test_rotate();
        @(negedge clk);
        Pin = 8'h96; load_valid = 1'b1; SW = 1'b1; shift_en = 1'b1;
        for (int r = 0; r < 3; r++) push_word(8'h96);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k <= 24) begin
                e = exp_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last || load_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rotate_bit k=%0d got v=%b s=%b l=%b r=%b exp v=1 s=%b l=%b r=0",
                             k, sout_valid, Sout, sout_last, load_ready, e.b, e.last);
                end
            end else begin
                checks++;
                if (sout_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rotate_exit got v=%b exp 0", sout_valid);
                end
            end
            if (k == 1) Pin = 8'h00;
            if (k == 24) begin
                SW = 1'b0;
                load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        Pin = 8'hFF; load_valid = 1'b1; SW = 1'b0; shift_en = 1'b1;
        push_word(8'hFF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (sout_valid !== 1'b1 || Sout !== e.b) begin
                errors++;
                $display("FAIL rstmid_bit k=%0d got v=%b s=%b exp v=1 s=%b", k, sout_valid, Sout, e.b);
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (Sout !== 1'b0 || sout_valid !== 1'b0 || sout_last !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async got s=%b v=%b l=%b r=%b exp 0 0 0 1",
                     Sout, sout_valid, sout_last, load_ready);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1; Pin = 8'h0F; load_valid = 1'b1;
        push_word(8'h0F);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (k <= 8) begin
                e = exp_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last) begin
                    errors++;
                    $display("FAIL rstmid_new k=%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             k, sout_valid, Sout, sout_last, e.b, e.last);
                end
            end else begin
                checks++;
                if (sout_valid !== 1'b0 || rx !== 8'h0F) begin
                    errors++;
                    $display("FAIL rstmid_done got v=%b rx=%h exp v=0 rx=0f", sout_valid, rx);
                end
            end
        end
    endtask

    task automatic test_loopback();
        localparam int N = 6;
        logic [W-1:0] w [N];
        for (int j = 0; j < N; j++) begin
            w[j] = W'($urandom_range(0, (1 << W) - 1));
            push_word(w[j]);
        end
        @(negedge clk);
        Pin = w[0]; load_valid = 1'b1; SW = 1'b0; shift_en = 1'b1;
        for (int k = 1; k <= 8 * N + 1; k++) begin
            @(negedge clk);
            if (k <= 8 * N) begin
                e = exp_q.pop_front();
                checks++;
                if (sout_valid !== 1'b1 || Sout !== e.b || sout_last !== e.last) begin
                    errors++;
                    $display("FAIL loop_bit k=%0d got v=%b s=%b l=%b exp v=1 s=%b l=%b",
                             k, sout_valid, Sout, sout_last, e.b, e.last);
                end
            end
            if (k > 1 && (k % 8) == 1) begin
                checks++;
                if (rx !== w[(k - 1) / 8 - 1]) begin
                    errors++;
                    $display("FAIL loop_rx word=%0d got %h exp %h", (k - 1) / 8 - 1, rx, w[(k - 1) / 8 - 1]);
                end
            end
            if ((k % 8) == 0 && k < 8 * N) Pin = w[k / 8];
            if (k == 8 * N) load_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_rotate();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: load_valid  input  1  upstream word-offer strobe.
REQ-005 Port: load_ready  output  1  block can accept a word this cycle.
REQ-006 Port: Pin  input  WIDTH  parallel word, sampled on a load handshake.
REQ-007 Port: SW  input  1  0 = one-shot (zero fill); 1 = rotate (Sout recirculates into LSB).
REQ-008 Port: shift_en  input  1  line-rate enable; shifting advances only while high.
REQ-009 Port: Sout  output  1  serial data, MSB first.
REQ-010 Port: sout_valid  output  1  Sout carries a word bit this cycle.
REQ-011 Port: sout_last  output  1  Sout carries bit 0 (final bit) of the current word.

Function
REQ-012 States SHALL be IDLE and SHIFT; internal state: shift register sreg[WIDTH-1:0] and bit counter cnt (0..WIDTH-1).
REQ-013 Sout SHALL equal sreg[WIDTH-1] in SHIFT and 0 in IDLE.
REQ-014 sout_valid SHALL be 1 exactly in SHIFT; sout_last SHALL be 1 when in SHIFT with cnt == WIDTH-1.
REQ-015 load_ready SHALL be 1 in IDLE, and in SHIFT only when cnt == WIDTH-1, shift_en == 1 and SW == 0; otherwise 0.
REQ-016 A handshake (load_valid && load_ready at a clock edge) SHALL load sreg <= Pin, cnt <= 0, state <= SHIFT; first bit Pin[WIDTH-1] appears on Sout in the next cycle (latency 1).
REQ-017 In SHIFT with shift_en == 1 and cnt < WIDTH-1: sreg <= {sreg[WIDTH-2:0], fill}, cnt <= cnt+1; fill = sreg[WIDTH-1] when SW == 1, else 0.
REQ-018 In SHIFT with shift_en == 0: sreg, cnt and state SHALL hold; Sout, sout_valid and sout_last SHALL hold their values.
REQ-019 At cnt == WIDTH-1 with shift_en == 1 and SW == 0: on a handshake, load the new word per REQ-016 (back-to-back, no gap); without one, state <= IDLE.
REQ-020 At cnt == WIDTH-1 with shift_en == 1 and SW == 1: rotate per REQ-017 (restoring the original word), cnt <= 0, stay in SHIFT; load_valid SHALL be ignored.
REQ-021 A change of SW mid-word SHALL take effect on the next shift edge only; bits already shifted out are not restored.
REQ-022 A word of WIDTH bits SHALL occupy exactly WIDTH shift_en-qualified cycles of sout_valid.
REQ-023 Bit order SHALL match the team's SIPO receiver: WIDTH shifts into that receiver reproduce Pin unchanged.

Reset
REQ-024 While rst is low: state = IDLE, sreg = 0, cnt = 0; hence Sout = 0, sout_valid = 0, sout_last = 0, load_ready = 1.
REQ-025 Reset asserted mid-word SHALL abort the word immediately; no partial word resumes after release.
REQ-026 The first handshake SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-027 Shared package piso_pkg SHALL hold WIDTH_DEFAULT (8) and the state enum (IDLE, SHIFT).
REQ-028 One sub-module, piso_bitcnt (modulo-WIDTH counter with enable, clear and terminal-count output), SHALL implement cnt; shifting and FSM stay in piso_tx.

Verification
REQ-029 Single word: Pin = 8'hA5, SW = 0, shift_en = 1 -> Sout = 1,0,1,0,0,1,0,1 on cycles 1..8; sout_last on cycle 8 only; IDLE with Sout = 0 on cycle 9.
REQ-030 Back-to-back: 8'h81 then 8'h7E offered with load_valid held -> 16 contiguous sout_valid cycles, second handshake on the last-bit edge, no gap.
REQ-031 Stall: 8'hC3, shift_en low for 3 cycles after bit 2 -> Sout holds bit 2 for 4 cycles, word completes in 11 cycles, bit sequence unchanged.
REQ-032 Rotate: 8'h96, SW = 1 for 24 cycles -> Sout repeats 1,0,0,1,0,1,1,0 three times, load_ready = 0 throughout, sout_last every 8th cycle.
REQ-033 Reset mid-word: rst low after bit 4 of 8'hFF -> Sout = 0, sout_valid = 0 asynchronously; after release, a new word 8'h0F transmits cleanly.
REQ-034 Loopback: Sout/sout_valid drive the team SIPO (its enable tied to sout_valid) with random words -> receiver parallel output equals each Pin after every sout_last.
